lut_access_arbiter: RTL and testbench

- Sequences one single-port coefficient LUT (registered address and registered output, 32-bit words) on behalf of N_REQ force-pipeline requesters plus one host configuration write port.
- Reads are arbitrated round-robin. Config writes take strict priority.
- Sits between the LJ evaluation pipelines and the LUT instance; the LUT itself stays external to this block.

---
 rtl/lut_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/lut_access_arbiter.sv | 110 +++++++++++
 tb/tb_lut_access_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared types and defaults for the coefficient LUT access path.
package lut_pkg;
    localparam int LUT_WORD_W     = 32;
    localparam int LUT_DEPTH_DEF  = 3072;
    localparam int LUT_ADDR_W_DEF = 12;
    // Tag id field is sized for up to 16 requesters; narrower ids zero-extend.
    localparam int TAG_ID_W       = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                err;
    } tag_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin grant generator; the pointer advances past the winner on accept.
module rr_arbiter import lut_pkg::*; #(
    parameter  int N   = 2,
    localparam int IDW = id_width(N)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           block,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);
    logic [IDW-1:0] ptr;

    // Search upward from the pointer, wrapping; a grant is always an accept.
    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!block && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= '0;
        else if (|grant)
            ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: rtl/lut_access_arbiter.sv
// Shares one single-port coefficient LUT between N_REQ readers and a host write port.
module lut_access_arbiter import lut_pkg::*; #(
    parameter int N_REQ      = 2,
    parameter int DEPTH      = LUT_DEPTH_DEF,
    parameter int ADDR_WIDTH = LUT_ADDR_W_DEF,
    parameter int RD_LAT     = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [LUT_WORD_W-1:0]       rsp_data,
    output logic                        rsp_err,
    input  logic                        cfg_valid,
    input  logic [ADDR_WIDTH-1:0]       cfg_addr,
    input  logic [LUT_WORD_W-1:0]       cfg_data,
    output logic                        cfg_ready,
    output logic                        cfg_err,
    output logic [ADDR_WIDTH-1:0]       lut_address,
    output logic [LUT_WORD_W-1:0]       lut_data,
    output logic                        lut_rden,
    output logic                        lut_wren,
    input  logic [LUT_WORD_W-1:0]       lut_q,
    output logic                        busy
);
    localparam int                  IDW     = id_width(N_REQ);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [IDW-1:0]        gnt_id;
    logic                  rd_fire, rd_ok, cfg_fire, cfg_ok, tag_any, err_hold;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [LUT_WORD_W-1:0] data_hold;
    tag_t                  tag_pipe [RD_LAT:0];
    tag_t                  head;

    assign cfg_ready = !reset;
    assign cfg_fire  = cfg_valid && !reset;

    // Any pending write blocks all read grants for the cycle.
    rr_arbiter #(.N(N_REQ)) u_arb (
        .clock    (clock),
        .reset    (reset),
        .req      (req_valid),
        .block    (cfg_valid | reset),
        .grant    (req_ready),
        .grant_id (gnt_id)
    );

    assign rd_fire = |req_ready;
    assign rd_addr = req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_ok   = {1'b0, rd_addr} < DEPTH_L;
    assign cfg_ok  = {1'b0, cfg_addr} < DEPTH_L;

    always_ff @(posedge clock) begin
        if (reset) begin
            lut_rden    <= 1'b0;
            lut_wren    <= 1'b0;
            lut_address <= '0;
            lut_data    <= '0;
            cfg_err     <= 1'b0;
            data_hold   <= '0;
            err_hold    <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            lut_rden <= 1'b0;
            lut_wren <= 1'b0;
            cfg_err  <= 1'b0;
            if (cfg_fire) begin
                if (cfg_ok) begin
                    lut_wren    <= 1'b1;
                    lut_address <= cfg_addr;
                    lut_data    <= cfg_data;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (rd_fire && rd_ok) begin
                lut_rden    <= 1'b1;
                lut_address <= rd_addr;
            end
            // Out-of-range reads still ride the tag pipe so responses stay in grant order.
            tag_pipe[0] <= '{valid: rd_fire, id: TAG_ID_W'(gnt_id), err: rd_fire && !rd_ok};
            for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            data_hold <= rsp_data;
            err_hold  <= rsp_err;
        end
    end

    assign head = tag_pipe[RD_LAT];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++)
            rsp_valid[i] = head.valid && (head.id == TAG_ID_W'(i));
        rsp_data = data_hold;
        rsp_err  = err_hold;
        if (head.valid) begin
            rsp_err  = head.err;
            rsp_data = head.err ? '0 : lut_q;
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) tag_any = tag_any | tag_pipe[i].valid;
    end

    assign busy = (|req_valid) | cfg_valid | tag_any;
endmodule

// File: tb/tb_lut_access_arbiter.sv
// Directed + random bench for lut_access_arbiter with a transaction-level reference model.
module tb_lut_access_arbiter;
    localparam int N_REQ  = 2;
    localparam int DEPTH  = 3072;
    localparam int AW     = 12;
    localparam int RD_LAT = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ*AW-1:0]   req_addr = '0;
    logic [N_REQ-1:0]      req_ready, rsp_valid;
    logic [31:0]           rsp_data;
    logic                  rsp_err;
    logic                  cfg_valid = 1'b0;
    logic [AW-1:0]         cfg_addr = '0;
    logic [31:0]           cfg_data = '0;
    logic                  cfg_ready, cfg_err;
    logic [AW-1:0]         lut_address;
    logic [31:0]           lut_data;
    logic                  lut_rden, lut_wren;
    logic [31:0]           lut_q = '0;
    logic                  busy;

    lut_access_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .lut_address(lut_address), .lut_data(lut_data),
        .lut_rden(lut_rden), .lut_wren(lut_wren), .lut_q(lut_q), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int a);
        return (a == 5) ? 32'h3F80_0000 : ((32'(a) * 32'h9E37_79B9) ^ 32'hA5A5_0000);
    endfunction

    // External LUT: address sampled on rden, word appears two edges later.
    logic [31:0] lut_mem [4096];
    bit          lut_wr_flag [4096];
    logic [31:0] lut_q1 = '0;
    always @(posedge clock) begin
        if (lut_wren) begin
            lut_mem[lut_address]     <= lut_data;
            lut_wr_flag[lut_address] <= 1'b1;
        end
        if (lut_rden)
            lut_q1 <= lut_wr_flag[lut_address] ? lut_mem[lut_address] : init_word(int'(lut_address));
        lut_q <= lut_q1;
    end

    // Reference model state: expected memory, pointer, response queue, next LUT command.
    typedef struct { int due; int id; bit err; logic [31:0] data; } exp_rsp_t;
    exp_rsp_t    rq[$];
    logic [31:0] ref_mem [4096];
    int          p = 0, cyc_n = 0, checks = 0, failures = 0;
    bit          e_rden, e_wren, e_cerr, hold_err;
    logic [AW-1:0] e_addr;
    logic [31:0] e_data, hold_data;
    logic [N_REQ-1:0] obs_ready, obs_rsp_valid;
    logic [31:0] obs_rsp_data;
    logic [AW-1:0] obs_addr;
    bit          obs_rsp_err, obs_rden, obs_wren, obs_cerr, obs_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_n, obs, want);
        end
    endtask

    task automatic model_clear();
        p = 0; rq.delete();
        e_rden = 0; e_wren = 0; e_cerr = 0; e_addr = '0; e_data = '0;
        hold_data = '0; hold_err = 0;
    endtask

    task automatic run_cycle(input logic [1:0] rv, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic cv, input logic [AW-1:0] ca, input logic [31:0] cd);
        logic [N_REQ-1:0] x_ready, x_vld;
        logic [31:0] x_data;
        logic [AW-1:0] ra;
        bit x_err, x_busy;
        int g;
        req_valid = rv; req_addr = {a1, a0};
        cfg_valid = cv; cfg_addr = ca; cfg_data = cd;
        @(negedge clock);
        g = -1;
        if (!cv)
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (p + k) % N_REQ;
                if (g < 0 && rv[i]) g = i;
            end
        x_ready = '0;
        if (g >= 0) x_ready[g] = 1'b1;
        x_busy = (|rv) | cv | (rq.size() > 0);
        x_vld = '0; x_data = hold_data; x_err = hold_err;
        if (rq.size() > 0 && rq[0].due == cyc_n) begin
            x_vld[rq[0].id] = 1'b1;
            x_err  = rq[0].err;
            x_data = rq[0].err ? 32'h0 : rq[0].data;
            void'(rq.pop_front());
        end
        hold_data = x_data; hold_err = x_err;
        chk("req_ready", 32'(req_ready), 32'(x_ready));
        chk("cfg_ready", 32'(cfg_ready), 32'd1);
        chk("lut_rden", 32'(lut_rden), 32'(e_rden));
        chk("lut_wren", 32'(lut_wren), 32'(e_wren));
        if (e_rden || e_wren) chk("lut_address", 32'(lut_address), 32'(e_addr));
        if (e_wren) chk("lut_data", lut_data, e_data);
        chk("cfg_err", 32'(cfg_err), 32'(e_cerr));
        chk("rsp_valid", 32'(rsp_valid), 32'(x_vld));
        chk("rsp_data", rsp_data, x_data);
        chk("rsp_err", 32'(rsp_err), 32'(x_err));
        chk("busy", 32'(busy), 32'(x_busy));
        obs_ready = req_ready; obs_rsp_valid = rsp_valid; obs_rsp_data = rsp_data;
        obs_rsp_err = rsp_err; obs_rden = lut_rden; obs_wren = lut_wren;
        obs_cerr = cfg_err; obs_busy = busy; obs_addr = lut_address;
        e_rden = 0; e_wren = 0; e_cerr = 0;
        if (cv) begin
            if (int'(ca) < DEPTH) begin
                e_wren = 1; e_addr = ca; e_data = cd; ref_mem[ca] = cd;
            end else e_cerr = 1;
        end else if (g >= 0) begin
            ra = (g == 1) ? a1 : a0;
            if (int'(ra) < DEPTH) begin e_rden = 1; e_addr = ra; end
            rq.push_back('{cyc_n + 1 + RD_LAT, g, int'(ra) >= DEPTH, ref_mem[ra]});
            p = (g + 1) % N_REQ;
        end
        @(posedge clock); #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(2'b00, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic reset_cycles(input int n, input bit check_vals);
        reset = 1'b1; req_valid = '0; cfg_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (check_vals && i == n - 1) begin
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_rsp_data", rsp_data, 32'd0);
                chk("rst_rsp_err", 32'(rsp_err), 32'd0);
                chk("rst_cfg_err", 32'(cfg_err), 32'd0);
                chk("rst_lut_rden", 32'(lut_rden), 32'd0);
                chk("rst_lut_wren", 32'(lut_wren), 32'd0);
                chk("rst_lut_address", 32'(lut_address), 32'd0);
                chk("rst_lut_data", lut_data, 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
            end
            @(posedge clock); #1;
            cyc_n++;
        end
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [AW-1:0] ra0, ra1, ca;
        for (int a = 0; a < 4096; a++) ref_mem[a] = init_word(a);
        model_clear();
        #1;
        reset_cycles(2, 1'b1);

        // Single read of word 5.
        run_cycle(2'b01, 12'd5, '0, 1'b0, '0, '0);
        chk("single_grant", 32'(obs_ready), 32'h1);
        idle(1);
        chk("single_rden", 32'(obs_rden), 32'd1);
        chk("single_addr", 32'(obs_addr), 32'd5);
        idle(2);
        chk("single_rsp_valid", 32'(obs_rsp_valid), 32'h1);
        chk("single_rsp_data", obs_rsp_data, 32'h3F80_0000);

        // Contention from reset: grants alternate.
        reset_cycles(1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_cycle(2'b11, AW'(10 + k), AW'(200 + k), 1'b0, '0, '0);
            chk("cont_grant", 32'(obs_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
        idle(4);

        // Write priority over a waiting reader.
        for (int k = 0; k < 3; k++) begin
            run_cycle(2'b10, '0, 12'd33, 1'b1, AW'(300 + k), 32'hC0DE_0000 + 32'(k));
            chk("wprio_ready", 32'(obs_ready), 32'h0);
        end
        run_cycle(2'b10, '0, 12'd33, 1'b0, '0, '0);
        chk("wprio_grant4", 32'(obs_ready), 32'h2);
        chk("wprio_wren", 32'(obs_wren), 32'd1);
        idle(4);

        // Write then immediate read of the same word.
        run_cycle(2'b00, '0, '0, 1'b1, 12'd100, 32'hDEAD_BEEF);
        run_cycle(2'b01, 12'd100, '0, 1'b0, '0, '0);
        idle(3);
        chk("wr_rd_data", obs_rsp_data, 32'hDEAD_BEEF);

        // Out-of-range read and write.
        run_cycle(2'b01, 12'd3072, '0, 1'b0, '0, '0);
        idle(1);
        chk("oor_no_rden", 32'(obs_rden), 32'd0);
        idle(2);
        chk("oor_rsp_valid", 32'(obs_rsp_valid), 32'h1);
        chk("oor_rsp_err", 32'(obs_rsp_err), 32'd1);
        chk("oor_rsp_data", obs_rsp_data, 32'd0);
        run_cycle(2'b00, '0, '0, 1'b1, 12'd4000, 32'h1234_5678);
        idle(1);
        chk("oor_cfg_err", 32'(obs_cerr), 32'd1);
        chk("oor_no_wren", 32'(obs_wren), 32'd0);
        idle(1);

        // Reset with two reads in flight.
        run_cycle(2'b01, 12'd7, '0, 1'b0, '0, '0);
        run_cycle(2'b01, 12'd8, '0, 1'b0, '0, '0);
        reset_cycles(1, 1'b0);
        idle(1);
        chk("mid_rst_rsp_t3", 32'(obs_rsp_valid), 32'h0);
        idle(1);
        chk("mid_rst_rsp_t4", 32'(obs_rsp_valid), 32'h0);
        chk("mid_rst_busy", 32'(obs_busy), 32'd0);
        run_cycle(2'b11, 12'd9, 12'd10, 1'b0, '0, '0);
        chk("mid_rst_ptr0", 32'(obs_ready), 32'h1);
        idle(4);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ra0 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 4095)) : AW'($urandom_range(0, DEPTH - 1));
            ra1 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 4095)) : AW'($urandom_range(0, DEPTH - 1));
            ca  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 4095)) : AW'($urandom_range(0, DEPTH - 1));
            run_cycle(2'($urandom), ra0, ra1, $urandom_range(0, 7) == 0, ca, $urandom);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
